// File: rtl/keccak_cmd_sequencer.sv
// keccak_cmd_sequencer: queues 64-bit Keccak commands from the host and plays
// them into the SHA/SHAKE BRAM wrapper's command registers one at a time.
// Each command is written as reg1 (lengths), then reg0 (opcode). The block waits
// for completion, then parks the wrapper on the idle opcode (31).
// Optional feature macro: KECCAK_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that
// drives timeout_err; without it timeout_err is tied low.
//
// Push handshake: cmd_push is accepted on any rising edge where cmd_full is low.
// cmd_full reflects the count before any same-cycle pop. A push while full is
// dropped and latches overflow_err. Pops happen only from IDLE while run is high.
module keccak_cmd_sequencer #(
    parameter int DEPTH          = 8,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cmd_wdata,
    input  logic        cmd_push,
    output logic        cmd_full,
    input  logic        run,
    output logic        busy,
    output logic        seq_done,
    output logic [15:0] ops_done,
    output logic        illegal_err,
    output logic        overflow_err,
    output logic        timeout_err,
    output logic [31:0] command_in,
    output logic        command_we0,
    output logic        command_we1,
    output logic        command_enable,
    input  logic        done_shake,
    output logic [2:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] IDLE_OPCODE = 32'd31;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD1  = 3'd1,
        S_LD0  = 3'd2,
        S_CLR  = 3'd3,
        S_WAIT = 3'd4,
        S_PARK = 3'd5
    } state_t;

    state_t          state;
    logic [63:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [63:0]     cur;
    logic [3:0]      clr_cnt;
    logic [15:0]     wait_cnt;
    logic            push_ok;
    logic            pop;
    logic [4:0]      cur_ins;

    assign cmd_full  = (count == (AW+1)'(DEPTH));
    assign busy      = (state != S_IDLE);
    assign seq_done  = (state == S_IDLE) && (count == '0);
    assign push_ok   = cmd_push && !cmd_full;
    assign pop       = (state == S_IDLE) && run && (count != '0);
    assign cur_ins   = cur[4:0];
    assign state_dbg = state;

`ifdef KECCAK_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Queue storage; entries need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cmd_wdata;
    end

    // Queue pointers, occupancy and the dropped-push flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (cmd_push && cmd_full) overflow_err <= 1'b1;
        end
    end

    // Command FSM; strobes are registered, so each transition loads the
    // outputs that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cur            <= '0;
            clr_cnt        <= '0;
            wait_cnt       <= '0;
            ops_done       <= '0;
            illegal_err    <= 1'b0;
            command_in     <= '0;
            command_we0    <= 1'b0;
            command_we1    <= 1'b0;
            command_enable <= 1'b0;
`ifdef KECCAK_SEQ_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
        end else begin
            command_in     <= '0;
            command_we0    <= 1'b0;
            command_we1    <= 1'b0;
            command_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur         <= mem[rd_ptr];
                        command_in  <= mem[rd_ptr][63:32];
                        command_we1 <= 1'b1;
                        state       <= S_LD1;
                    end
                end
                S_LD1: begin
                    // Opcode write happens only for clear and real Keccak ops.
                    if (cur_ins <= 5'd5) begin
                        command_in  <= cur[31:0];
                        command_we0 <= 1'b1;
                    end else if (cur_ins != 5'd31) begin
                        illegal_err <= 1'b1;
                    end
                    state <= S_LD0;
                end
                S_LD0: begin
                    if (cur_ins == 5'd0) begin
                        command_enable <= 1'b1;
                        clr_cnt        <= 4'd1;
                        state          <= S_CLR;
                    end else if (cur_ins <= 5'd5) begin
                        command_enable <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= S_WAIT;
                    end else begin
                        command_in  <= IDLE_OPCODE;
                        command_we0 <= 1'b1;
                        state       <= S_PARK;
                    end
                end
                S_CLR: begin
                    if (clr_cnt == 4'(CLR_CYCLES)) begin
                        command_in  <= IDLE_OPCODE;
                        command_we0 <= 1'b1;
                        state       <= S_PARK;
                    end else begin
                        clr_cnt        <= clr_cnt + 4'd1;
                        command_enable <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // The first two WAIT cycles may still see the previous done.
                    if (wait_cnt >= 16'd2 && done_shake) begin
                        command_in  <= IDLE_OPCODE;
                        command_we0 <= 1'b1;
                        state       <= S_PARK;
`ifdef KECCAK_SEQ_TIMEOUT_EN
                    end else if (wait_cnt == WD_LAST) begin
                        timeout_q   <= 1'b1;
                        command_in  <= IDLE_OPCODE;
                        command_we0 <= 1'b1;
                        state       <= S_PARK;
`endif
                    end else begin
                        command_enable <= 1'b1;
                        if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_PARK: begin
                    ops_done <= ops_done + 16'd1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_cmd_sequencer.sv
// Directed bench for keccak_cmd_sequencer: single command timing, stale done,
// queue full/wrap, mixed opcodes, reset in WAIT and the optional watchdog.
module tb_keccak_cmd_sequencer;

    localparam int DEPTH          = 8;
    localparam int CLR_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cmd_wdata;
    logic        cmd_push;
    logic        cmd_full;
    logic        run;
    logic        busy;
    logic        seq_done;
    logic [15:0] ops_done;
    logic        illegal_err;
    logic        overflow_err;
    logic        timeout_err;
    logic [31:0] command_in;
    logic        command_we0;
    logic        command_we1;
    logic        command_enable;
    logic        done_shake;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    keccak_cmd_sequencer #(
        .DEPTH(DEPTH), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .cmd_wdata(cmd_wdata), .cmd_push(cmd_push),
        .cmd_full(cmd_full), .run(run), .busy(busy), .seq_done(seq_done),
        .ops_done(ops_done), .illegal_err(illegal_err),
        .overflow_err(overflow_err), .timeout_err(timeout_err),
        .command_in(command_in), .command_we0(command_we0),
        .command_we1(command_we1), .command_enable(command_enable),
        .done_shake(done_shake), .state_dbg(state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: one-cycle push, returns in the following cycle.
    task automatic push(input logic [63:0] d);
        cmd_wdata = d;
        cmd_push  = 1'b1;
        tick();
        cmd_push  = 1'b0;
    endtask

    function automatic logic [34:0] strobes();
        return {command_we1, command_we0, command_enable, command_in};
    endfunction

    function automatic logic [34:0] mk(input logic w1, input logic w0, input logic en,
                                       input logic [31:0] d);
        return {w1, w0, en, d};
    endfunction

    // Expected strobes for the mixed-opcode run, cycle k after run rises.
    function automatic logic [34:0] exp_mixed(input int k);
        case (k)
            1:       return mk(1, 0, 0, 32'h1111_0000);
            2:       return mk(0, 1, 0, 32'h0000_0000);
            3, 4:    return mk(0, 0, 1, 32'h0);
            5, 9, 13, 20: return mk(0, 1, 0, 32'd31);
            7:       return mk(1, 0, 0, 32'h2222_0000);
            11:      return mk(1, 0, 0, 32'h3333_0000);
            15:      return mk(1, 0, 0, 32'h0010_0008);
            16:      return mk(0, 1, 0, 32'h0000_0002);
            17, 18, 19: return mk(0, 0, 1, 32'h0);
            default: return mk(0, 0, 0, 32'h0);
        endcase
    endfunction

    initial begin
        int got;
        rst = 1'b1; cmd_wdata = '0; cmd_push = 1'b0; run = 1'b0; done_shake = 1'b0;
        tick(); tick();
        // Reset state
        check_eq("rst_strobes", 64'(strobes()), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_seq_done", 64'(seq_done), 64'd1);
        check_eq("rst_ops", 64'(ops_done), 64'd0);
        check_eq("rst_state", 64'(state_dbg), 64'd0);
        rst = 1'b0;
        run = 1'b1;

        // Single SHAKE command, done rises in cycle 9
        push(64'h0040_0020_0000_0003);                  // now cycle 1
        check_eq("t1_c1_busy", 64'(busy), 64'd0);
        tick();                                          // cycle 2
        check_eq("t1_ld1", 64'(strobes()), 64'(mk(1, 0, 0, 32'h0040_0020)));
        tick();                                          // cycle 3
        check_eq("t1_ld0", 64'(strobes()), 64'(mk(0, 1, 0, 32'h0000_0003)));
        tick();                                          // cycle 4
        check_eq("t1_wait", 64'(strobes()), 64'(mk(0, 0, 1, 32'h0)));
        check_eq("t1_busy", 64'(busy), 64'd1);
        repeat (5) tick();                               // cycle 9
        done_shake = 1'b1;
        tick();                                          // cycle 10
        done_shake = 1'b0;
        check_eq("t1_park", 64'(strobes()), 64'(mk(0, 1, 0, 32'd31)));
        tick();                                          // cycle 11
        check_eq("t1_ops", 64'(ops_done), 64'd1);
        check_eq("t1_seq_done", 64'(seq_done), 64'd1);
        check_eq("t1_idle_strobes", 64'(strobes()), 64'd0);

        // Stale done held high: PARK exactly in cycle 7
        done_shake = 1'b1;
        push(64'h0010_0010_0000_0001);                  // cycle 1
        tick(); tick(); tick();                          // cycle 4
        for (int c = 4; c <= 6; c++) begin
            check_eq($sformatf("t2_guard_c%0d", c), 64'(strobes()), 64'(mk(0, 0, 1, 32'h0)));
            tick();
        end                                              // cycle 7
        check_eq("t2_park_c7", 64'(strobes()), 64'(mk(0, 1, 0, 32'd31)));
        done_shake = 1'b0;
        tick();
        check_eq("t2_ops", 64'(ops_done), 64'd2);

        // Queue full with run low, then FIFO drain across pointer wrap
        run = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [63:0] d;
            d = {16'hA000 | 16'(i), 16'h0B00 | 16'(i), 27'(i + 1), 5'd31};
            exp_q.push_back(d);
            push(d);
        end
        check_eq("t3_full", 64'(cmd_full), 64'd1);
        check_eq("t3_no_ovf_yet", 64'(overflow_err), 64'd0);
        push(64'hDEAD_BEEF_0000_001F);
        check_eq("t3_ovf", 64'(overflow_err), 64'd1);
        check_eq("t3_still_full", 64'(cmd_full), 64'd1);
        run = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (command_we1) begin
                got++;
                if (exp_q.size() == 0)
                    check_eq("t3_extra_cmd", 64'(command_in), 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    check_eq($sformatf("t3_fifo_%0d", got), 64'(command_in),
                             64'(exp_q.pop_front() >> 32));
            end
            if (command_we0 && command_in != 32'd31)
                check_eq("t3_nop_wrote", 64'(command_in), 64'd31);
        end
        check_eq("t3_count", 64'(got), 64'(DEPTH));
        check_eq("t3_ops", 64'(ops_done), 64'd10);
        check_eq("t3_seq_done", 64'(seq_done), 64'd1);

        // Mixed opcodes: clear, NOP, illegal 7, INS 2
        run = 1'b0;
        push({32'h1111_0000, 32'h0000_0000});
        push({32'h2222_0000, 32'h0000_001F});
        push({32'h3333_0000, 32'h0000_0007});
        push({32'h0010_0008, 32'h0000_0002});
        check_eq("t4_illegal_pre", 64'(illegal_err), 64'd0);
        run = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            if (k == 17) done_shake = 1'b1;
            if (k == 20) done_shake = 1'b0;
            check_eq($sformatf("t4_k%0d", k), 64'(strobes()), 64'(exp_mixed(k)));
            if (k == 11) check_eq("t4_illegal_before", 64'(illegal_err), 64'd0);
            if (k == 12) check_eq("t4_illegal_set", 64'(illegal_err), 64'd1);
            tick();
        end
        check_eq("t4_ops", 64'(ops_done), 64'd14);
        check_eq("t4_seq_done", 64'(seq_done), 64'd1);

        // Reset while in WAIT with another command queued
        push(64'h0001_0001_0000_0001);
        got = 0;
        for (int c = 0; c < 10 && !command_enable; c++) tick();
        check_eq("t5_reached_wait", 64'(command_enable), 64'd1);
        push(64'h0002_0002_0000_0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_strobes", 64'(strobes()), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_empty", 64'(seq_done), 64'd1);
        check_eq("t5_full", 64'(cmd_full), 64'd0);
        check_eq("t5_errs", 64'({illegal_err, overflow_err, timeout_err}), 64'd0);
        check_eq("t5_ops", 64'(ops_done), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (command_we0 || command_we1) got++;
        end
        check_eq("t5_no_park", 64'(got), 64'd0);

`ifdef KECCAK_SEQ_TIMEOUT_EN
        // Watchdog: done stuck low, timeout on the 20th WAIT cycle
        push(64'h0001_0001_0000_0001);                  // cycle 1
        tick(); tick(); tick();                          // cycle 4
        repeat (TIMEOUT_CYCLES - 1) tick();              // cycle 23
        check_eq("t6_last_wait", 64'({timeout_err, command_we0, command_enable}), 64'b001);
        tick();                                          // cycle 24
        check_eq("t6_timeout", 64'(timeout_err), 64'd1);
        check_eq("t6_park", 64'(strobes()), 64'(mk(0, 1, 0, 32'd31)));
        tick();
        check_eq("t6_ops", 64'(ops_done), 64'd1);
`else
        // No watchdog: WAIT outlasts the timeout parameter, then completes on done
        push(64'h0001_0001_0000_0001);
        tick(); tick(); tick();
        repeat (30) tick();
        check_eq("t6_still_wait", 64'({timeout_err, command_enable, busy}), 64'b011);
        done_shake = 1'b1;
        tick();
        done_shake = 1'b0;
        check_eq("t6_park", 64'(strobes()), 64'(mk(0, 1, 0, 32'd31)));
        tick();
        check_eq("t6_ops", 64'(ops_done), 64'd1);
        check_eq("t6_no_timeout", 64'(timeout_err), 64'd0);
`endif

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/keccak_cmd_sequencer.md
# keccak_cmd_sequencer

Command initiator for the SHA/SHAKE BRAM wrapper. The host preloads a queue of 64-bit Keccak commands. The block then issues them to the wrapper's command registers one at a time, waits for `done_shake`, and parks the wrapper on the idle opcode before issuing the next command. It sits between the top-level controller and the Keccak core, so the controller no longer drives `command_in`/`command_we0`/`command_we1` directly.

## Interface
- `DEPTH`, 8: command queue entries (power of 2, ≥2).
- `CLR_CYCLES`, 2: cycles opcode 0 (clear) is held before parking (1..15).
- `TIMEOUT_CYCLES`, 65535: watchdog limit while waiting for `done_shake` (used only with `KECCAK_SEQ_TIMEOUT_EN`).
- `clk` in 1: single clock for everything; all flops rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_wdata` in 64: `{reg1_word[31:0], reg0_word[31:0]}`. reg0 = `{OP3[8:0], OP2[8:0], OP1[8:0], INS[4:0]}`; reg1 = `{olen[15:0], mlen[15:0]}`.
- `cmd_push` in 1: enqueue `cmd_wdata`.
- `cmd_full` out 1: queue full.
- `run` in 1: level; pops are allowed only while high.
- `busy` out 1: state ≠ IDLE.
- `seq_done` out 1: IDLE and queue empty.
- `ops_done` out 16: count of retired commands; wraps at 65535→0.
- `illegal_err` out 1: sticky; set when INS is in 6..30.
- `overflow_err` out 1: sticky; set when a push is dropped.
- `timeout_err` out 1: sticky; exists only with the macro, otherwise tied 0.
- `command_in` out 32: word written to the wrapper command register.
- `command_we0` out 1: write strobe for command register 0.
- `command_we1` out 1: write strobe for command register 1.
- `command_enable` out 1: high in WAIT and CLR.
- `done_shake` in 1: completion flag from the wrapper.

## Operation
- **Queue:** circular buffer with `DEPTH` entries and wrap-around read/write pointers plus a count.
  - `cmd_full` is evaluated before any same-cycle pop. A push while full is dropped and sets `overflow_err`.
- **FSM states:** IDLE, LD1, LD0, CLR, WAIT, PARK.
- **IDLE:** if `run` and the queue is non-empty, pop the head into `cur` and go to LD1.
- **LD1:** `command_in = cur[63:32]`, `command_we1 = 1`, go to LD0. Lengths are written first so the opcode becomes active last.
- **LD0:** dispatch on `cur[4:0]` (INS):
  - INS = 0: `command_in = cur[31:0]`, `command_we0 = 1`, go to CLR.
  - INS = 1..5: `command_in = cur[31:0]`, `command_we0 = 1`, go to WAIT.
  - INS = 31: NOP. No write; go to PARK.
  - INS = 6..30: no write; set `illegal_err`; go to PARK.
- **CLR:** hold for `CLR_CYCLES` cycles using a 4-bit counter, then go to PARK.
- **WAIT:** guard counter. `done_shake` is ignored during the first 2 WAIT cycles, because the previous command's done flag may still be high. From the 3rd WAIT cycle on, `done_shake = 1` → PARK.
- **PARK:** `command_in = 32'd31`, `command_we0 = 1` (idle opcode deasserts the wrapper's enable). Increment `ops_done`; go to IDLE.
  - Retired commands (counted in `ops_done`) include NOPs and illegal opcodes.
- **Strobes:** `command_we0` and `command_we1` are never both high. Outside the listed cycles both are 0 and `command_in` is 0.
- **`run` dropped mid-command:** the current command completes; no further pops.
- **`rst` at any time:** FSM → IDLE; pointers and count cleared; all outputs 0; sticky errors cleared; `ops_done` = 0.
  - No PARK write is issued on reset. The host must push a clear (INS = 0) command first after reset.

## Timing
- Push into an empty queue at cycle 0 with `run` high:
  - cycle 1: entry visible, pop (IDLE);
  - cycle 2: LD1;
  - cycle 3: LD0;
  - cycle 4: first WAIT cycle.
- Earliest `done_shake` acceptance is cycle 6. PARK is the cycle after the accepting cycle.
- Back-to-back: the next LD1 follows PARK by 2 cycles (PARK → IDLE/pop → LD1).
- A clear command occupies LD1 + LD0 + `CLR_CYCLES` + PARK + IDLE cycles.
- All outputs are registered, except `cmd_full`, `busy` and `seq_done`, which are decoded from registered state.

## Configuration
- **With `KECCAK_SEQ_TIMEOUT_EN` defined:**
  - A 16-bit watchdog counts WAIT cycles.
  - Reaching `TIMEOUT_CYCLES` without an accepted `done_shake` sets `timeout_err` and goes to PARK; the command still counts as retired.
- **Without the macro:** no watchdog; WAIT can last indefinitely; `timeout_err` = 0.

## Test plan
- **Single SHAKE command:** push 64'h0040_0020_0000_0003, `done_shake` rises in cycle 9.
  - Required: cycle 2 `we1` with 32'h0040_0020; cycle 3 `we0` with 32'h0000_0003; PARK in cycle 10 writes 32'd31; `ops_done` = 1; `seq_done` = 1 in cycle 11.
- **Stale done:** hold `done_shake = 1` throughout. Required: PARK occurs exactly in cycle 7; no earlier acceptance.
- **Queue full:** push `DEPTH`+1 entries with `run` = 0. Required: `cmd_full` after `DEPTH` pushes, `overflow_err` = 1, 8 entries retained. Then `run` = 1: all 8 are issued in FIFO order (pointer wrap checked).
- **Mixed opcodes:** push INS 0, 31, 7, 2.
  - Clear held for `CLR_CYCLES`; NOP produces no `we0` in LD0; INS 7 sets `illegal_err` with no `we0` in LD0; INS 2 waits for done.
  - Final `ops_done` = 4.
- **Reset in WAIT:** assert `rst` for 1 cycle. Required: next cycle all outputs 0, `busy` = 0, queue empty, no PARK write.
- **Watchdog (macro on, `TIMEOUT_CYCLES` = 20):** `done_shake` stuck at 0. Required: `timeout_err` = 1 after 20 WAIT cycles, PARK follows, `ops_done` = 1.
